// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 8;
    localparam int SIG_W       = 8;

endpackage

// File: rtl/truth_table_sweeper_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit gate output.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Shift the asynchronous input through two flops; both clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight input vectors of a 3-input gate, samples its output after
// each dwell and assembles an 8-bit truth-table signature (MSB = vector 000).
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int DWELL_W   = 16,
    parameter int MIN_DWELL = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SIG_W-1:0]   expect_sig,
    output logic               in1,
    output logic               in2,
    output logic               in3,
    input  logic               gate_out,
    output logic               busy,
    output logic               done,
    output logic [SIG_W-1:0]   signature,
    output logic               match
);

    state_t             state_reg, state_next;
    logic [2:0]         idx_reg, idx_next;
    logic [2:0]         vec_reg, vec_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic [DWELL_W-1:0] eff_reg, eff_next;
    logic [SIG_W-1:0]   exp_reg, exp_next;
    logic [SIG_W-1:0]   sig_reg, sig_next;
    logic               match_reg, match_next;

    logic               gs;
    logic [DWELL_W-1:0] dwell_clamped;
    logic [2:0]         bit_pos;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gate_out),
        .q     (gs)
    );

    // Short dwells cannot cover the synchroniser latency, so they are raised.
    assign dwell_clamped = (dwell < DWELL_W'(MIN_DWELL)) ? DWELL_W'(MIN_DWELL) : dwell;
    // Vector 000 lands in the MSB so the signature reads like the gate's name.
    assign bit_pos       = 3'(NUM_VECTORS - 1) - idx_reg;

    // State and datapath registers; everything returns to idle on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            vec_reg   <= '0;
            cnt_reg   <= '0;
            eff_reg   <= '0;
            exp_reg   <= '0;
            sig_reg   <= '0;
            match_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            vec_reg   <= vec_next;
            cnt_reg   <= cnt_next;
            eff_reg   <= eff_next;
            exp_reg   <= exp_next;
            sig_reg   <= sig_next;
            match_reg <= match_next;
        end
    end

    // Sweep sequencing: dwell countdown, bit capture, vector advance, abort.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        vec_next   = vec_reg;
        cnt_next   = cnt_reg;
        eff_next   = eff_reg;
        exp_next   = exp_reg;
        sig_next   = sig_reg;
        match_next = match_reg;

        case (state_reg)
            IDLE: begin
                vec_next = '0;
                // abort has priority, so a simultaneous start is dropped
                if (start && !abort) begin
                    exp_next   = expect_sig;
                    eff_next   = dwell_clamped;
                    cnt_next   = dwell_clamped - DWELL_W'(1);
                    idx_next   = '0;
                    sig_next   = '0;
                    match_next = 1'b0;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    // partial signature is kept; match was cleared at start
                    vec_next   = '0;
                    state_next = IDLE;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - DWELL_W'(1);
                end else begin
                    sig_next[bit_pos] = gs;
                    if (idx_reg == 3'(NUM_VECTORS - 1)) begin
                        // released here so vector 111 is held exactly one dwell
                        vec_next   = '0;
                        match_next = (sig_next == exp_reg);
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                        vec_next = idx_reg + 3'd1;
                        cnt_next = eff_reg - DWELL_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign {in1, in2, in3} = vec_reg;
    assign busy            = (state_reg == DRIVE);
    assign done            = (state_reg == DONE);
    assign signature       = sig_reg;
    assign match           = match_reg;

endmodule
